// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard sequencer for the RV32IM 5-stage core: PC/IF/ID/EX hold and flush
// controls for branches, load-use, imem wait states and multi-cycle MUL/DIV in EX.
module pipeline_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_use_rs1,
  input  logic        ID_use_rs2,
  input  logic        ID_muldiv,
  input  logic        ID_div,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_rd,
  input  logic        EX_branch_taken,
  input  logic        imem_ready,
  input  logic        stat_clr,
  output logic        PC_Stall,
  output logic        IF_Stall,
  output logic        IF_Flush,
  output logic        ID_Bubble,
  output logic        EX_Hold,
  output logic        md_busy,
  output logic [15:0] stall_count
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;

  logic load_use;
  logic pc_stall, if_stall, if_flush, id_bubble, ex_hold;

  assign load_use = EX_MemRead && (EX_rd != '0) &&
                    ((ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                     (ID_use_rs2 && (ID_rs2 == EX_rd)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_stall  = 1'b0;
    if_stall  = 1'b0;
    if_flush  = 1'b0;
    id_bubble = 1'b0;
    ex_hold   = 1'b0;
    unique case (state_q)
      MD_BUSY: begin
        pc_stall = 1'b1;
        if_stall = 1'b1;
        ex_hold  = 1'b1;
        cnt_d    = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = RUN;
      end
      default: begin
        if (EX_branch_taken) begin
          if_flush  = 1'b1;
          id_bubble = 1'b1;
        end else if (load_use) begin
          pc_stall  = 1'b1;
          if_stall  = 1'b1;
          id_bubble = 1'b1;
        end else begin
          // MD issue and imem wait are independent and may both apply
          if (ID_muldiv) begin
            state_d = MD_BUSY;
            cnt_d   = ID_div ? DIV_LOAD : MUL_LOAD;
          end
          if (!imem_ready) begin
            pc_stall = 1'b1;
            if_flush = 1'b1;
          end
        end
      end
    endcase
  end

  // Outputs are forced low while reset is held, whatever the inputs do
  assign PC_Stall  = RESET && pc_stall;
  assign IF_Stall  = RESET && if_stall;
  assign IF_Flush  = RESET && if_flush;
  assign ID_Bubble = RESET && id_bubble;
  assign EX_Hold   = RESET && ex_hold;
  assign md_busy   = RESET && (state_q == MD_BUSY);

  always_comb begin
    stall_d = stall_q;
    if (stat_clr)                          stall_d = '0;
    else if (PC_Stall && (stall_q != '1))  stall_d = stall_q + 16'd1;
  end

  assign stall_count = stall_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: per-cycle expected controls and stall
// counter are queued when stimulus is applied and popped when the cycle is sampled.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  ID_rs1, ID_rs2, EX_rd;
  logic        ID_use_rs1, ID_use_rs2, ID_muldiv, ID_div;
  logic        EX_MemRead, EX_branch_taken, imem_ready, stat_clr;
  logic        PC_Stall, IF_Stall, IF_Flush, ID_Bubble, EX_Hold, md_busy;
  logic [15:0] stall_count;
  logic [5:0]  ctl_obs;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(33)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .ID_muldiv(ID_muldiv), .ID_div(ID_div), .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
    .EX_branch_taken(EX_branch_taken), .imem_ready(imem_ready), .stat_clr(stat_clr),
    .PC_Stall(PC_Stall), .IF_Stall(IF_Stall), .IF_Flush(IF_Flush), .ID_Bubble(ID_Bubble),
    .EX_Hold(EX_Hold), .md_busy(md_busy), .stall_count(stall_count)
  );

  // {PC_Stall, IF_Stall, IF_Flush, ID_Bubble, EX_Hold, md_busy}
  assign ctl_obs = {PC_Stall, IF_Stall, IF_Flush, ID_Bubble, EX_Hold, md_busy};

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_FLUSH = 6'b001100;
  localparam logic [5:0] C_LU    = 6'b110100;
  localparam logic [5:0] C_MD    = 6'b110011;
  localparam logic [5:0] C_IMEM  = 6'b101000;

  typedef struct packed {
    logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2; logic md; logic dv;
    logic mr; logic [4:0] rd; logic br; logic im; logic clr; logic [5:0] ectl;
  } stim_t;

  typedef struct packed { logic [5:0] ctl; logic [15:0] cnt; } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_sc;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic stim_t mk(input int rs1, input int rs2, input int u1, input int u2,
                               input int md, input int dv, input int mr, input int rd,
                               input int br, input int im, input int clr, input logic [5:0] c);
    stim_t s;
    s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.u1 = 1'(u1); s.u2 = 1'(u2);
    s.md = 1'(md); s.dv = 1'(dv); s.mr = 1'(mr); s.rd = 5'(rd);
    s.br = 1'(br); s.im = 1'(im); s.clr = 1'(clr); s.ectl = c;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    ID_rs1 = s.rs1; ID_rs2 = s.rs2; ID_use_rs1 = s.u1; ID_use_rs2 = s.u2;
    ID_muldiv = s.md; ID_div = s.dv; EX_MemRead = s.mr; EX_rd = s.rd;
    EX_branch_taken = s.br; imem_ready = s.im; stat_clr = s.clr;
  endtask

  // Advance one edge and update the expected stall counter for that edge
  task automatic advance(input logic pc_stall_exp);
    @(posedge CLK); #1;
    if (stat_clr) exp_sc = '0;
    else if (pc_stall_exp && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
  endtask

  task automatic test_reset;
    stim_t q[$];
    exp_t  e;
    RESET = 1'b0;
    exp_sc = '0;
    apply(mk(5, 5, 1, 1, 1, 1, 1, 5, 1, 0, 0, C_NONE));
    repeat (2) @(negedge CLK);
    vectors++;
    if (ctl_obs !== C_NONE) begin
      miscompares++; $display("FAIL rst_ctl: got %b want %b", ctl_obs, C_NONE);
    end
    vectors++;
    if (stall_count !== 16'h0) begin
      miscompares++; $display("FAIL rst_cnt: got %0d want 0", stall_count);
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_FLUSH));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE));
    foreach (q[i]) begin
      apply(q[i]); sb.push_back({q[i].ectl, exp_sc});
      @(negedge CLK); e = sb.pop_front();
      vectors++;
      if (ctl_obs !== e.ctl) begin
        miscompares++; $display("FAIL rst_rel_ctl step %0d: got %b want %b", i, ctl_obs, e.ctl);
      end
      vectors++;
      if (stall_count !== e.cnt) begin
        miscompares++; $display("FAIL rst_rel_cnt step %0d: got %0d want %0d", i, stall_count, e.cnt);
      end
      advance(e.ctl[5]);
    end
  endtask

  task automatic test_load_use;
    stim_t q[$];
    exp_t  e;
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE));
    q.push_back(mk(3, 5, 1, 1, 0, 0, 1, 5, 0, 1, 0, C_LU));
    q.push_back(mk(3, 5, 1, 1, 0, 0, 0, 5, 0, 1, 0, C_NONE));
    q.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, C_NONE));
    q.push_back(mk(7, 2, 1, 0, 0, 0, 1, 7, 0, 1, 0, C_LU));
    q.push_back(mk(7, 2, 0, 1, 0, 0, 1, 7, 0, 1, 0, C_NONE));
    q.push_back(mk(7, 7, 0, 0, 0, 0, 1, 7, 0, 1, 0, C_NONE));
    q.push_back(mk(5, 0, 1, 0, 1, 1, 1, 5, 0, 1, 0, C_LU));
    q.push_back(mk(5, 0, 1, 0, 0, 0, 0, 5, 0, 1, 0, C_NONE));
    foreach (q[i]) begin
      apply(q[i]); sb.push_back({q[i].ectl, exp_sc});
      @(negedge CLK); e = sb.pop_front();
      vectors++;
      if (ctl_obs !== e.ctl) begin
        miscompares++; $display("FAIL lu_ctl step %0d: got %b want %b", i, ctl_obs, e.ctl);
      end
      vectors++;
      if (stall_count !== e.cnt) begin
        miscompares++; $display("FAIL lu_cnt step %0d: got %0d want %0d", i, stall_count, e.cnt);
      end
      advance(e.ctl[5]);
    end
  endtask

  task automatic test_branch_vs_hazard;
    stim_t q[$];
    exp_t  e;
    q.push_back(mk(4, 4, 1, 1, 0, 0, 1, 4, 1, 1, 0, C_FLUSH));
    q.push_back(mk(4, 4, 1, 1, 1, 1, 1, 4, 1, 0, 0, C_FLUSH));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_FLUSH));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, C_FLUSH));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE));
    foreach (q[i]) begin
      apply(q[i]); sb.push_back({q[i].ectl, exp_sc});
      @(negedge CLK); e = sb.pop_front();
      vectors++;
      if (ctl_obs !== e.ctl) begin
        miscompares++; $display("FAIL br_ctl step %0d: got %b want %b", i, ctl_obs, e.ctl);
      end
      vectors++;
      if (stall_count !== e.cnt) begin
        miscompares++; $display("FAIL br_cnt step %0d: got %0d want %0d", i, stall_count, e.cnt);
      end
      advance(e.ctl[5]);
    end
  endtask

  task automatic test_div;
    stim_t q[$];
    exp_t  e;
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE));
    q.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, C_NONE));
    for (int i = 0; i < 32; i++) begin
      // Branches, load-use, imem waits and a fresh muldiv are all ignored while busy
      q.push_back(mk(6, 0, 1, 0, (i == 5) ? 1 : 0, 0, (i % 7 == 3) ? 1 : 0, 6,
                     (i % 4 == 1) ? 1 : 0, (i % 5 == 2) ? 0 : 1, 0, C_MD));
    end
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE));
    foreach (q[i]) begin
      apply(q[i]); sb.push_back({q[i].ectl, exp_sc});
      @(negedge CLK); e = sb.pop_front();
      vectors++;
      if (ctl_obs !== e.ctl) begin
        miscompares++; $display("FAIL div_ctl step %0d: got %b want %b", i, ctl_obs, e.ctl);
      end
      vectors++;
      if (stall_count !== e.cnt) begin
        miscompares++; $display("FAIL div_cnt step %0d: got %0d want %0d", i, stall_count, e.cnt);
      end
      advance(e.ctl[5]);
    end
    vectors++;
    if (stall_count !== 16'd32) begin
      miscompares++; $display("FAIL div_total: got %0d want 32", stall_count);
    end
  endtask

  task automatic test_back_to_back;
    stim_t q[$];
    exp_t  e;
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, C_NONE));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, C_MD));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, C_NONE));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MD));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_IMEM));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MD));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE));
    foreach (q[i]) begin
      apply(q[i]); sb.push_back({q[i].ectl, exp_sc});
      @(negedge CLK); e = sb.pop_front();
      vectors++;
      if (ctl_obs !== e.ctl) begin
        miscompares++; $display("FAIL b2b_ctl step %0d: got %b want %b", i, ctl_obs, e.ctl);
      end
      vectors++;
      if (stall_count !== e.cnt) begin
        miscompares++; $display("FAIL b2b_cnt step %0d: got %0d want %0d", i, stall_count, e.cnt);
      end
      advance(e.ctl[5]);
    end
  endtask

  task automatic test_reset_abort;
    stim_t q[$];
    exp_t  e;
    q.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, C_NONE));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MD));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MD));
    foreach (q[i]) begin
      apply(q[i]); sb.push_back({q[i].ectl, exp_sc});
      @(negedge CLK); e = sb.pop_front();
      vectors++;
      if (ctl_obs !== e.ctl) begin
        miscompares++; $display("FAIL abort_pre_ctl step %0d: got %b want %b", i, ctl_obs, e.ctl);
      end
      advance(e.ctl[5]);
    end
    RESET = 1'b0;
    @(negedge CLK);
    vectors++;
    if (ctl_obs !== C_NONE) begin
      miscompares++; $display("FAIL abort_rst_ctl: got %b want %b", ctl_obs, C_NONE);
    end
    vectors++;
    if (stall_count !== 16'h0) begin
      miscompares++; $display("FAIL abort_rst_cnt: got %0d want 0", stall_count);
    end
    exp_sc = '0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    q.delete();
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, C_NONE));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MD));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE));
    foreach (q[i]) begin
      apply(q[i]); sb.push_back({q[i].ectl, exp_sc});
      @(negedge CLK); e = sb.pop_front();
      vectors++;
      if (ctl_obs !== e.ctl) begin
        miscompares++; $display("FAIL abort_post_ctl step %0d: got %b want %b", i, ctl_obs, e.ctl);
      end
      vectors++;
      if (stall_count !== e.cnt) begin
        miscompares++; $display("FAIL abort_post_cnt step %0d: got %0d want %0d", i, stall_count, e.cnt);
      end
      advance(e.ctl[5]);
    end
  endtask

  task automatic test_imem_saturation;
    stim_t q[$];
    exp_t  e;
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IMEM));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IMEM));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IMEM));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE));
    foreach (q[i]) begin
      apply(q[i]); sb.push_back({q[i].ectl, exp_sc});
      @(negedge CLK); e = sb.pop_front();
      vectors++;
      if (ctl_obs !== e.ctl) begin
        miscompares++; $display("FAIL imem_ctl step %0d: got %b want %b", i, ctl_obs, e.ctl);
      end
      vectors++;
      if (stall_count !== e.cnt) begin
        miscompares++; $display("FAIL imem_cnt step %0d: got %0d want %0d", i, stall_count, e.cnt);
      end
      advance(e.ctl[5]);
    end
    imem_ready = 1'b0;
    for (int n = 0; n < 65600; n++) advance(1'b1);
    @(negedge CLK);
    vectors++;
    if (stall_count !== 16'hFFFF) begin
      miscompares++; $display("FAIL sat_cnt: got %h want ffff", stall_count);
    end
    q.delete();
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IMEM));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_IMEM));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE));
    foreach (q[i]) begin
      apply(q[i]); sb.push_back({q[i].ectl, exp_sc});
      @(negedge CLK); e = sb.pop_front();
      vectors++;
      if (ctl_obs !== e.ctl) begin
        miscompares++; $display("FAIL clr_ctl step %0d: got %b want %b", i, ctl_obs, e.ctl);
      end
      vectors++;
      if (stall_count !== e.cnt) begin
        miscompares++; $display("FAIL clr_cnt step %0d: got %0d want %0d", i, stall_count, e.cnt);
      end
      advance(e.ctl[5]);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_vs_hazard();
    test_div();
    test_back_to_back();
    test_reset_abort();
    test_imem_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
